ins_fetch: RTL and testbench
============================

Name: ins_fetch

Overview:
- Instruction fetch stage; sits directly downstream of the program counter.
- Takes the PC's ins_address, runs a read handshake with the instruction memory, and latches the returned word into the instruction register (IR).
- Presents opcode/operand to the control unit and returns a one-cycle pc_adv pulse that tells the control unit the fetch is complete and PC may inc/load.
- One fetch per instruction, aligned to the 4-cycle instruction rhythm.

Parameters:
- ADDR_W, 8, instruction address width (matches PC).
- INS_W, 16, instruction word width.
- OPC_W, 4, opcode field width, taken from IR[INS_W-1 -: OPC_W].
- TMO_CYC, 15, wait-state limit; used only with IF_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  fetch enable; start/run flag from the control unit.
- ins_address  in  ADDR_W  current PC value.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address, registered.
- imem_rdata  in  INS_W  read data.
- imem_rvalid  in  1  read data valid, 1-cycle pulse.
- ir  out  INS_W  instruction register.
- opcode  out  OPC_W  IR opcode field.
- operand  out  INS_W-OPC_W  IR remaining bits.
- ir_valid  out  1  IR holds an unconsumed instruction.
- ir_ack  in  1  control unit has consumed the IR.
- pc_adv  out  1  one-cycle pulse: fetch complete.
- fetch_err  out  1  sticky timeout flag; tied 0 without IF_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync deassert by the upstream synchroniser): state=IDLE; imem_req=0, imem_addr=0, ir=0, ir_valid=0, pc_adv=0, fetch_err=0.
- opcode and operand are combinational slices of ir.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If enable=1 and ir_valid=0: go to REQ and capture imem_addr<=ins_address.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req=1 for exactly one cycle, then go to WAIT.
  - If imem_rvalid=1 already in REQ (zero wait): accept it as in WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid=1: ir<=imem_rdata, ir_valid<=1, pc_adv<=1 (next cycle, one cycle wide), go to HOLD.
- HOLD:
  - On ir_ack=1: ir_valid<=0 and go to IDLE; the next fetch can request on the following cycle.
  - ir keeps its value after ack until overwritten.
- Minimum latency from IDLE+enable to ir_valid is 3 cycles: REQ, WAIT with rvalid, ir_valid visible. With zero-wait memory and immediate ack this gives a 4-cycle instruction period.
- enable deasserted mid-fetch (REQ/WAIT): the outstanding read completes and the IR is latched. enable only gates starting a new fetch.
- imem_rvalid in IDLE or HOLD: ignored; no IR change.
- ir_ack while ir_valid=0: ignored.
- ins_address changing after capture: no effect until the next IDLE→REQ.
- Reset mid-WAIT: the FSM returns to IDLE and a later rvalid is ignored.
- Address wraps naturally at 2^ADDR_W; no special handling.

Optional Feature:
- Macro: IF_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter runs in WAIT.
  - When it reaches TMO_CYC without imem_rvalid: fetch_err<=1 (sticky until reset), ir<=0 (treated as NOP), ir_valid<=1, no pc_adv, go to HOLD.
  - The counter clears on entry to REQ.
- Undefined: no counter; WAIT lasts indefinitely; fetch_err is constant 0.

Decomposition:
- Shared package ins_pkg holds:
  - ADDR_W, INS_W, OPC_W defaults.
  - FSM state encoding localparams: IDLE=2'b00, REQ=2'b01, WAIT=2'b10, HOLD=2'b11.
  - Opcode constants used by the decoder, including NOP=0.
- Natural sub-module: ins_fetch_tmo (wait counter plus compare), instantiated only under IF_TIMEOUT_EN.

Test Plan:
- Reset low mid-stream, then release → all outputs 0; state IDLE; no imem_req until enable=1.
- enable=1, ins_address=8'h05, memory returns 16'hA123 with zero wait → imem_req high 1 cycle with imem_addr=8'h05; ir=16'hA123, opcode=4'hA, operand=12'h123 on the 3rd cycle; pc_adv 1-cycle pulse; ir_ack next cycle → IDLE.
- rvalid delayed 5 cycles → imem_req pulses once only; ir_valid rises the cycle after rvalid; ins_address changed to 8'h09 during WAIT does not alter imem_addr (stays 8'h05).
- ir_ack held off 10 cycles while enable=1 → no new imem_req until one cycle after ack; spurious imem_rvalid during HOLD leaves ir unchanged.
- Reset asserted during WAIT, then rvalid arrives after release → ir stays 0; ir_valid=0.
- IF_TIMEOUT_EN defined, no rvalid → after 15 WAIT cycles: fetch_err=1, ir=0, ir_valid=1, no pc_adv. Macro undefined → fetch_err remains 0 indefinitely.

Source files
------------

// File: rtl/ins_pkg.sv
// Shared widths, FSM encoding and opcode constants for the instruction fetch slice.
package ins_pkg;

  localparam int ADDR_W  = 8;
  localparam int INS_W   = 16;
  localparam int OPC_W   = 4;
  localparam int TMO_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_t;

  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OPC_STA = 4'h4;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

  function automatic logic [OPC_W-1:0] opc_of(input logic [INS_W-1:0] ins);
    return ins[INS_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Instruction memory read port: one-cycle request, data returned with a one-cycle rvalid pulse.
interface ins_fetch_if;

  logic                       imem_req;
  logic [ins_pkg::ADDR_W-1:0] imem_addr;
  logic [ins_pkg::INS_W-1:0]  imem_rdata;
  logic                       imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );

endinterface

// File: rtl/ins_fetch_tmo.sv
// Wait-state counter for the fetch WAIT state; hit is raised on the last allowed wait cycle.
// Only instantiated when IF_TIMEOUT_EN is defined.
module ins_fetch_tmo #(
  parameter int TMO_CYC = ins_pkg::TMO_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic hit
);

  logic [3:0] cnt;

  assign hit = run && (cnt == 4'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && !hit) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: IDLE->REQ->WAIT->HOLD, latches the memory word into IR and pulses pc_adv.
// Optional wait-state timeout under macro IF_TIMEOUT_EN (fetch_err sticky, IR forced to NOP).
module ins_fetch
  import ins_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ADDR_W-1:0]      ins_address,
  ins_fetch_if.master            imem,
  output logic [INS_W-1:0]       ir,
  output logic [OPC_W-1:0]       opcode,
  output logic [INS_W-OPC_W-1:0] operand,
  output logic                   ir_valid,
  input  logic                   ir_ack,
  output logic                   pc_adv,
  output logic                   fetch_err
);

  fetch_state_t state;
  logic         start;
  logic         rd_take;
  logic         tmo_hit;
  logic         tmo_take;

  assign opcode  = opc_of(ir);
  assign operand = ir[INS_W-OPC_W-1:0];

  assign start   = (state == IDLE) && enable && !ir_valid;
  // A response arriving while the request is still on the bus is accepted the same as in WAIT.
  assign rd_take = imem.imem_rvalid && ((state == REQ) || (state == WAIT));

`ifdef IF_TIMEOUT_EN
  ins_fetch_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .run   (state == WAIT),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err <= 1'b0;
    end else if (tmo_take) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign tmo_take = (state == WAIT) && !imem.imem_rvalid && tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      ir             <= '0;
      ir_valid       <= 1'b0;
      pc_adv         <= 1'b0;
    end else begin
      pc_adv <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            imem.imem_addr <= ins_address;
            imem.imem_req  <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          imem.imem_req <= 1'b0;
          if (rd_take) begin
            ir       <= imem.imem_rdata;
            ir_valid <= 1'b1;
            pc_adv   <= 1'b1;
            state    <= HOLD;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (rd_take) begin
            ir       <= imem.imem_rdata;
            ir_valid <= 1'b1;
            pc_adv   <= 1'b1;
            state    <= HOLD;
          end else if (tmo_take) begin
            // Timed-out fetch hands the control unit a NOP without advancing the PC.
            ir       <= {OPC_NOP, {(INS_W-OPC_W){1'b0}}};
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ack) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: stimulus pushes expected requests/IR words, a negedge monitor pops and compares.
module tb_ins_fetch;
  import ins_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   enable = 1'b0;
  logic                   ir_ack = 1'b0;
  logic [ADDR_W-1:0]      ins_address = '0;
  logic [INS_W-1:0]       ir;
  logic [OPC_W-1:0]       opcode;
  logic [INS_W-OPC_W-1:0] operand;
  logic                   ir_valid;
  logic                   pc_adv;
  logic                   fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] exp_req_q[$];
  logic [INS_W-1:0]  exp_ir_q[$];
  logic [INS_W-1:0]  mon_exp;

  ins_fetch_if imem();

  ins_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ins_address (ins_address),
    .imem        (imem),
    .ir          (ir),
    .opcode      (opcode),
    .operand     (operand),
    .ir_valid    (ir_valid),
    .ir_ack      (ir_ack),
    .pc_adv      (pc_adv),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (imem.imem_req) begin
        if (exp_req_q.size() == 0) chk("unexpected imem_req", 32'(imem.imem_req), 32'd0);
        else                       chk("imem_addr", 32'(imem.imem_addr), 32'(exp_req_q.pop_front()));
      end
      if (pc_adv) begin
        if (exp_ir_q.size() == 0) begin
          chk("unexpected pc_adv", 32'(pc_adv), 32'd0);
        end else begin
          mon_exp = exp_ir_q.pop_front();
          chk("ir", 32'(ir), 32'(mon_exp));
          chk("opcode", 32'(opcode), 32'(mon_exp[INS_W-1 -: OPC_W]));
          chk("operand", 32'(operand), 32'(mon_exp[INS_W-OPC_W-1:0]));
          chk("ir_valid with pc_adv", 32'(ir_valid), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!imem.imem_req && n < 10);
    if (!imem.imem_req) chk("imem_req timeout", 32'(imem.imem_req), 32'd1);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] addr, input logic [INS_W-1:0] data,
                       input int wait_n, input int ack_dly, input bit keep_en);
    int n;
    exp_req_q.push_back(addr);
    exp_ir_q.push_back(data);
    ins_address = addr;
    enable      = 1'b1;
    wait_req(n);
    chk("req latency", 32'(n), 32'd1);
    step();
    for (int i = 0; i < wait_n; i++) begin
      chk("ir_valid in WAIT", 32'(ir_valid), 32'd0);
      if (i == 1) ins_address = addr + 8'h04;
      step();
    end
    chk("imem_addr held", 32'(imem.imem_addr), 32'(addr));
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = data;
    if (!keep_en) enable = 1'b0;
    step();
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 16'h0BAD;
    chk("ir_valid after rvalid", 32'(ir_valid), 32'd1);
    chk("pc_adv pulse", 32'(pc_adv), 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      chk("no req in HOLD", 32'(imem.imem_req), 32'd0);
      if (i == 1) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 16'hDEAD;
      end
      if (i == 2) imem.imem_rvalid = 1'b0;
      step();
      if (i == 0) chk("pc_adv width", 32'(pc_adv), 32'd0);
    end
    imem.imem_rvalid = 1'b0;
    chk("ir held in HOLD", 32'(ir), 32'(data));
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    chk("ir_valid after ack", 32'(ir_valid), 32'd0);
    chk("ir kept after ack", 32'(ir), 32'(data));
    if (ack_dly == 0) chk("pc_adv width", 32'(pc_adv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;

    // Reset state
    #12;
    chk("rst imem_req", 32'(imem.imem_req), 32'd0);
    chk("rst imem_addr", 32'(imem.imem_addr), 32'd0);
    chk("rst ir", 32'(ir), 32'd0);
    chk("rst ir_valid", 32'(ir_valid), 32'd0);
    chk("rst pc_adv", 32'(pc_adv), 32'd0);
    chk("rst fetch_err", 32'(fetch_err), 32'd0);
    step();
    reset = 1'b1;
    ins_address = 8'h44;
    repeat (4) begin
      step();
      chk("idle no req", 32'(imem.imem_req), 32'd0);
    end

    // Zero-wait fetch, immediate ack
    fetch(8'h05, 16'hA123, 0, 0, 1'b0);
    // Delayed rvalid, address changes during WAIT
    fetch(8'h05, 16'h5C3E, 5, 2, 1'b0);
    // Ack held off with enable high, then back-to-back fetch
    fetch(8'h20, 16'h7BCD, 1, 10, 1'b1);
    fetch(8'h21, 16'h3456, 0, 0, 1'b0);

    // Stray rvalid and ack in IDLE
    step();
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 16'hEEEE;
    ir_ack = 1'b1;
    step();
    imem.imem_rvalid = 1'b0;
    ir_ack = 1'b0;
    chk("idle rvalid ignored", 32'(ir), 32'h3456);
    chk("idle ack ignored", 32'(ir_valid), 32'd0);

    // Reset during WAIT, late rvalid ignored
    exp_req_q.push_back(8'h30);
    ins_address = 8'h30;
    enable = 1'b1;
    wait_req(n);
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("mid rst ir", 32'(ir), 32'd0);
    chk("mid rst imem_req", 32'(imem.imem_req), 32'd0);
    chk("mid rst imem_addr", 32'(imem.imem_addr), 32'd0);
    step();
    reset = 1'b1;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 16'hBEEF;
    step();
    imem.imem_rvalid = 1'b0;
    step();
    chk("late rvalid ir", 32'(ir), 32'd0);
    chk("late rvalid ir_valid", 32'(ir_valid), 32'd0);

    fetch(8'hFE, 16'h9ABC, 2, 0, 1'b0);

    // Long wait: timeout when enabled, indefinite wait otherwise
    exp_req_q.push_back(8'hFF);
    ins_address = 8'hFF;
    enable = 1'b1;
    wait_req(n);
    enable = 1'b0;
    repeat (15) step();
    chk("wait15 ir_valid", 32'(ir_valid), 32'd0);
    step();
`ifdef IF_TIMEOUT_EN
    chk("tmo ir_valid", 32'(ir_valid), 32'd1);
    chk("tmo fetch_err", 32'(fetch_err), 32'd1);
    chk("tmo ir nop", 32'(ir), 32'd0);
    chk("tmo no pc_adv", 32'(pc_adv), 32'd0);
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    step();
    chk("tmo err sticky", 32'(fetch_err), 32'd1);
    chk("tmo ack ir_valid", 32'(ir_valid), 32'd0);
`else
    repeat (10) step();
    chk("no tmo ir_valid", 32'(ir_valid), 32'd0);
    chk("no tmo fetch_err", 32'(fetch_err), 32'd0);
    exp_ir_q.push_back(16'h1FFF);
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = 16'h1FFF;
    step();
    imem.imem_rvalid = 1'b0;
    chk("slow ir_valid", 32'(ir_valid), 32'd1);
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    step();
    chk("slow fetch_err", 32'(fetch_err), 32'd0);
`endif

    repeat (3) step();
    chk("req queue drained", 32'(exp_req_q.size()), 32'd0);
    chk("ir queue drained", 32'(exp_ir_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
